mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 42 ++++
 rtl/mem_access.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Bundle of execute-side request, data-memory bus and writeback signals for the memory stage.
interface mem_access_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid_in;
    logic                    ready_out;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic [DATA_WIDTH-1:0]   store_data;
    logic                    mem_read;
    logic                    mem_write;
    logic [2:0]              funct3;
    logic [4:0]              rd_in;
    logic                    reg_write_in;

    logic                    dmem_req;
    logic                    dmem_we;
    logic [DATA_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic [DATA_WIDTH/8-1:0] dmem_be;
    logic                    dmem_ack;
    logic [DATA_WIDTH-1:0]   dmem_rdata;

    logic                    valid_out;
    logic [DATA_WIDTH-1:0]   wb_data;
    logic [4:0]              rd_out;
    logic                    reg_write_out;
    logic                    misalign;

    modport slave (
        input  valid_in, alu_result, store_data, mem_read, mem_write, funct3, rd_in, reg_write_in,
        input  dmem_ack, dmem_rdata,
        output ready_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output valid_out, wb_data, rd_out, reg_write_out, misalign
    );

    modport master (
        output valid_in, alu_result, store_data, mem_read, mem_write, funct3, rd_in, reg_write_in,
        output dmem_ack, dmem_rdata,
        input  ready_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  valid_out, wb_data, rd_out, reg_write_out, misalign
    );
endinterface

// File: rtl/mem_access.sv
// Pipeline memory stage: issues aligned loads/stores on a req/ack data bus and
// produces one registered writeback result per accepted operation.
module mem_access #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_access_if.slave   bus
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_is_mem;
    logic                  w_misalign;
    logic [1:0]            w_size;
    logic [BE_W-1:0]       w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_lane_word;
    logic                  w_sbit;
    logic [DATA_WIDTH-1:0] w_load_data;

    logic                  r_dmem_req;
    logic                  r_dmem_we;
    logic [DATA_WIDTH-1:0] r_dmem_addr;
    logic [DATA_WIDTH-1:0] r_dmem_wdata;
    logic [BE_W-1:0]       r_dmem_be;
    logic                  r_valid_out;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [4:0]            r_rd_out;
    logic                  r_reg_write_out;
    logic                  r_misalign;

    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_is_load;
    logic [4:0]            r_pend_rd;
    logic                  r_pend_rw;

    // Request decode: size 00 byte, 01 half, anything else (incl. undefined funct3) word
    always_comb begin
        w_ready    = (r_state != BUSY);
        w_accept   = bus.valid_in & w_ready;
        w_is_mem   = bus.mem_read | bus.mem_write;
        w_size     = bus.funct3[1:0];
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = bus.store_data;
        case (w_size)
            2'b00: begin
                w_be    = BE_W'(1) << bus.alu_result[1:0];
                w_wdata = {4{bus.store_data[7:0]}};
            end
            2'b01: begin
                w_misalign = bus.alu_result[0];
                w_be       = bus.alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{bus.store_data[15:0]}};
            end
            default: begin
                w_misalign = |bus.alu_result[1:0];
            end
        endcase
    end

    // Load lane extraction from the returned word
    always_comb begin
        w_lane_word = bus.dmem_rdata >> {r_lane, 3'b000};
        w_sbit      = 1'b0;
        w_load_data = w_lane_word;
        case (r_size)
            2'b00: begin
                w_sbit      = ~r_unsigned & w_lane_word[7];
                w_load_data = {{(DATA_WIDTH-8){w_sbit}}, w_lane_word[7:0]};
            end
            2'b01: begin
                w_sbit      = ~r_unsigned & w_lane_word[15];
                w_load_data = {{(DATA_WIDTH-16){w_sbit}}, w_lane_word[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, RESP: begin
                if (!w_accept)                    w_state_next = IDLE;
                else if (!w_is_mem || w_misalign) w_state_next = RESP;
                else                              w_state_next = BUSY;
            end
            BUSY:    if (bus.dmem_ack) w_state_next = RESP;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Bus request and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_dmem_addr     <= '0;
            r_dmem_wdata    <= '0;
            r_dmem_be       <= '0;
            r_valid_out     <= 1'b0;
            r_wb_data       <= '0;
            r_rd_out        <= '0;
            r_reg_write_out <= 1'b0;
            r_misalign      <= 1'b0;
            r_lane          <= '0;
            r_size          <= '0;
            r_unsigned      <= 1'b0;
            r_is_load       <= 1'b0;
            r_pend_rd       <= '0;
            r_pend_rw       <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (r_state == BUSY && bus.dmem_ack) begin
                r_dmem_req      <= 1'b0;
                r_valid_out     <= 1'b1;
                r_wb_data       <= r_is_load ? w_load_data : '0;
                r_rd_out        <= r_pend_rd;
                r_reg_write_out <= r_is_load & r_pend_rw;
                r_misalign      <= 1'b0;
            end
            if (w_accept) begin
                if (!w_is_mem) begin
                    r_valid_out     <= 1'b1;
                    r_wb_data       <= bus.alu_result;
                    r_rd_out        <= bus.rd_in;
                    r_reg_write_out <= bus.reg_write_in & (|bus.rd_in);
                    r_misalign      <= 1'b0;
                end else if (w_misalign) begin
                    r_valid_out     <= 1'b1;
                    r_wb_data       <= '0;
                    r_rd_out        <= bus.rd_in;
                    r_reg_write_out <= 1'b0;
                    r_misalign      <= 1'b1;
                end else begin
                    // A simultaneous read and write is a load
                    r_dmem_req   <= 1'b1;
                    r_dmem_we    <= bus.mem_write & ~bus.mem_read;
                    r_dmem_addr  <= {bus.alu_result[DATA_WIDTH-1:2], 2'b00};
                    r_dmem_wdata <= w_wdata;
                    r_dmem_be    <= w_be;
                    r_lane       <= bus.alu_result[1:0];
                    r_size       <= w_size;
                    r_unsigned   <= bus.funct3[2];
                    r_is_load    <= bus.mem_read;
                    r_pend_rd    <= bus.rd_in;
                    r_pend_rw    <= bus.reg_write_in & (|bus.rd_in);
                end
            end
        end
    end

    assign bus.ready_out     = w_ready;
    assign bus.dmem_req      = r_dmem_req;
    assign bus.dmem_we       = r_dmem_we;
    assign bus.dmem_addr     = r_dmem_addr;
    assign bus.dmem_wdata    = r_dmem_wdata;
    assign bus.dmem_be       = r_dmem_be;
    assign bus.valid_out     = r_valid_out;
    assign bus.wb_data       = r_wb_data;
    assign bus.rd_out        = r_rd_out;
    assign bus.reg_write_out = r_reg_write_out;
    assign bus.misalign      = r_misalign;
endmodule
